// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl -- machine-mode trap controller for the single-hart core.
//
// Arbitrates synchronous exceptions from EX against the external and timer
// interrupts, records mepc/mcause/mtval, and sequences a pipeline flush
// followed by a PC redirect. The redirect goes to the trap vector, or to mepc
// on mret.
//
// Configuration macro:
//   TRAP_IRQ_SYNC_EN  defined   : ext_irq passes a 2-flop synchroniser (meip latency 2)
//                     undefined : ext_irq is registered once (meip latency 1)
//
// Ports:
//   cpu_clk, cpu_rstn           clock, asynchronous active-low reset
//   instr_valid_ex, pc_ex       EX-stage instruction valid and PC
//   exc_*                       exception requests from EX
//   illegal_instr, mem_addr     trap values for illegal / misaligned traps
//   mret_ex                     mret in EX
//   ext_irq, timer_irq          raw interrupt levels
//   meie, mtie, mstatus_mie     interrupt enables
//   mtvec_mode, mtvec_base      trap vector configuration
//   mepc_sel/mcause_sel/mtval_sel, valid_mcsr_wr, mcsr_set, mcsr_clr,
//   write_data                  CSR write port for mepc/mcause/mtval
//   meip, mtip                  registered pending bits
//   mepc, mcause, mtval         trap CSRs
//   valid_interrupt, mret       accept-cycle pulses (combinational)
//   pipe_flush, trap_busy,
//   trap_redirect, trap_target  pipeline control for the flush/redirect sequence
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module trap_ctrl (
    input  logic                    cpu_clk,
    input  logic                    cpu_rstn,
    input  logic                    instr_valid_ex,
    input  logic [`ADDR_WIDTH-1:0]  pc_ex,
    input  logic                    exc_illegal,
    input  logic [`INSTR_WIDTH-1:0] illegal_instr,
    input  logic                    exc_ebreak,
    input  logic                    exc_ecall,
    input  logic                    exc_ld_misalign,
    input  logic                    exc_st_misalign,
    input  logic [`ADDR_WIDTH-1:0]  mem_addr,
    input  logic                    mret_ex,
    input  logic                    ext_irq,
    input  logic                    timer_irq,
    input  logic                    meie,
    input  logic                    mtie,
    input  logic                    mstatus_mie,
    input  logic [1:0]              mtvec_mode,
    input  logic [31:0]             mtvec_base,
    input  logic                    mepc_sel,
    input  logic                    mcause_sel,
    input  logic                    mtval_sel,
    input  logic                    valid_mcsr_wr,
    input  logic                    mcsr_set,
    input  logic                    mcsr_clr,
    input  logic [`DATA_WIDTH-1:0]  write_data,
    output logic                    meip,
    output logic                    mtip,
    output logic [`ADDR_WIDTH-1:0]  mepc,
    output logic [`DATA_WIDTH-1:0]  mcause,
    output logic [`DATA_WIDTH-1:0]  mtval,
    output logic                    valid_interrupt,
    output logic                    mret,
    output logic                    pipe_flush,
    output logic                    trap_busy,
    output logic                    trap_redirect,
    output logic [`ADDR_WIDTH-1:0]  trap_target
);

    localparam int AW = `ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT
    } state_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXC,
        EV_MRET,
        EV_IRQ
    } event_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   mepc_q, mepc_d;
    logic [DW-1:0]   mcause_q, mcause_d;
    logic [DW-1:0]   mtval_q, mtval_d;
    logic [AW-1:0]   target_q, target_d;
    logic            mtip_q;

    event_e          ev;
    logic [DW-1:0]   ev_cause;
    logic [DW-1:0]   ev_tval;
    logic [4:0]      ev_code;
    logic            ext_pend;
    logic            tmr_pend;

    // -------------------------------------------------------------------------
    // Interrupt pending bits
    // -------------------------------------------------------------------------
`ifdef TRAP_IRQ_SYNC_EN
    logic ext_sync1_q, ext_sync2_q;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            ext_sync1_q <= 1'b0;
            ext_sync2_q <= 1'b0;
        end else begin
            ext_sync1_q <= ext_irq;
            ext_sync2_q <= ext_sync1_q;
        end
    end

    assign meip = ext_sync2_q;
`else
    logic ext_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its sources regardless of block order.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            ext_q <= 1'b0;
        end else begin
            ext_q <= ext_irq;
        end
    end

    assign meip = ext_q;
`endif

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            mtip_q <= 1'b0;
        end else begin
            mtip_q <= timer_irq;
        end
    end

    assign mtip     = mtip_q;
    assign ext_pend = meip & meie & mstatus_mie;
    assign tmr_pend = mtip_q & mtie & mstatus_mie;

    // -------------------------------------------------------------------------
    // Event arbitration: only an IDLE controller with a valid EX instruction
    // accepts anything, so the instruction being flushed can never trap.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first; without it the
    // untaken branches would infer latches.
    always_comb begin
        ev       = EV_NONE;
        ev_cause = '0;
        ev_tval  = '0;
        ev_code  = 5'd0;
        if (state_q == ST_IDLE && instr_valid_ex) begin
            if (exc_illegal) begin
                ev       = EV_EXC;
                ev_cause = DW'(2);
                ev_tval  = DW'(illegal_instr);
            end else if (exc_ebreak) begin
                ev       = EV_EXC;
                ev_cause = DW'(3);
                ev_tval  = DW'(pc_ex);
            end else if (exc_ecall) begin
                ev       = EV_EXC;
                ev_cause = DW'(11);
            end else if (exc_ld_misalign) begin
                ev       = EV_EXC;
                ev_cause = DW'(4);
                ev_tval  = DW'(mem_addr);
            end else if (exc_st_misalign) begin
                ev       = EV_EXC;
                ev_cause = DW'(6);
                ev_tval  = DW'(mem_addr);
            end else if (mret_ex) begin
                ev       = EV_MRET;
            end else if (ext_pend) begin
                ev       = EV_IRQ;
                ev_code  = 5'd11;
                ev_cause = (DW'(1) << (DW - 1)) | DW'(11);
            end else if (tmr_pend) begin
                ev       = EV_IRQ;
                ev_code  = 5'd7;
                ev_cause = (DW'(1) << (DW - 1)) | DW'(7);
            end
        end
    end

    // Write / set / clear semantics shared by the three CSRs.
    function automatic logic [DW-1:0] csr_op(input logic [DW-1:0] old_v,
                                             input logic [DW-1:0] wdata,
                                             input logic          set_en,
                                             input logic          clr_en);
        if (set_en) begin
            return old_v | wdata;
        end else if (clr_en) begin
            return old_v & ~wdata;
        end
        return wdata;
    endfunction

    // -------------------------------------------------------------------------
    // Next state and CSR updates. A trap acceptance is applied last so it
    // overrides a CSR write landing in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        target_d = target_q;

        case (state_q)
            ST_IDLE:     if (ev != EV_NONE) state_d = ST_FLUSH;
            ST_FLUSH:    state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        if (valid_mcsr_wr) begin
            if (mepc_sel) begin
                mepc_d = AW'(csr_op(DW'(mepc_q), write_data, mcsr_set, mcsr_clr)) & ~AW'(3);
            end
            if (mcause_sel) begin
                mcause_d = csr_op(mcause_q, write_data, mcsr_set, mcsr_clr);
            end
            if (mtval_sel) begin
                mtval_d = csr_op(mtval_q, write_data, mcsr_set, mcsr_clr);
            end
        end

        if (ev == EV_EXC || ev == EV_IRQ) begin
            mepc_d   = pc_ex;
            mcause_d = ev_cause;
            mtval_d  = ev_tval;
            if (ev == EV_IRQ && mtvec_mode == 2'd1) begin
                target_d = AW'(mtvec_base) + (AW'(ev_code) << 2);
            end else begin
                target_d = AW'(mtvec_base);
            end
        end else if (ev == EV_MRET) begin
            // Return address is the mepc value before any same-cycle write.
            target_d = mepc_q;
        end
    end

    // NOTE: all control and CSR flops are reset (there is no memory array
    // here), so a reset mid-sequence drops any pending redirect.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q  <= ST_IDLE;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            target_q <= target_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mepc            = mepc_q;
    assign mcause          = mcause_q;
    assign mtval           = mtval_q;
    assign trap_target     = target_q;
    assign valid_interrupt = (ev == EV_IRQ);
    assign mret            = (ev == EV_MRET);
    assign pipe_flush      = (state_q == ST_FLUSH);
    assign trap_redirect   = (state_q == ST_REDIRECT);
    assign trap_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl -- self-checking bench for trap_ctrl.
//
// Directed scenarios for the key trap, interrupt, mret, CSR and reset cases,
// followed by randomized traffic. Every cycle is compared against a
// behavioural model of the trap rules: a priority resolver, a busy-cycle
// countdown for the flush/redirect sequence, and a delay line for the
// interrupt pending bits.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module tb_trap_ctrl;

`ifdef TRAP_IRQ_SYNC_EN
    localparam int IRQ_LAT = 2;
`else
    localparam int IRQ_LAT = 1;
`endif

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic        instr_valid_ex;
    logic [31:0] pc_ex;
    logic        exc_illegal;
    logic [31:0] illegal_instr;
    logic        exc_ebreak, exc_ecall, exc_ld_misalign, exc_st_misalign;
    logic [31:0] mem_addr;
    logic        mret_ex, ext_irq, timer_irq, meie, mtie, mstatus_mie;
    logic [1:0]  mtvec_mode;
    logic [31:0] mtvec_base;
    logic        mepc_sel, mcause_sel, mtval_sel, valid_mcsr_wr, mcsr_set, mcsr_clr;
    logic [31:0] write_data;
    logic        meip, mtip;
    logic [31:0] mepc, mcause, mtval;
    logic        valid_interrupt, mret, pipe_flush, trap_busy, trap_redirect;
    logic [31:0] trap_target;

    always #5 cpu_clk = ~cpu_clk;

    trap_ctrl dut (
        .cpu_clk         (cpu_clk),
        .cpu_rstn        (cpu_rstn),
        .instr_valid_ex  (instr_valid_ex),
        .pc_ex           (pc_ex),
        .exc_illegal     (exc_illegal),
        .illegal_instr   (illegal_instr),
        .exc_ebreak      (exc_ebreak),
        .exc_ecall       (exc_ecall),
        .exc_ld_misalign (exc_ld_misalign),
        .exc_st_misalign (exc_st_misalign),
        .mem_addr        (mem_addr),
        .mret_ex         (mret_ex),
        .ext_irq         (ext_irq),
        .timer_irq       (timer_irq),
        .meie            (meie),
        .mtie            (mtie),
        .mstatus_mie     (mstatus_mie),
        .mtvec_mode      (mtvec_mode),
        .mtvec_base      (mtvec_base),
        .mepc_sel        (mepc_sel),
        .mcause_sel      (mcause_sel),
        .mtval_sel       (mtval_sel),
        .valid_mcsr_wr   (valid_mcsr_wr),
        .mcsr_set        (mcsr_set),
        .mcsr_clr        (mcsr_clr),
        .write_data      (write_data),
        .meip            (meip),
        .mtip            (mtip),
        .mepc            (mepc),
        .mcause          (mcause),
        .mtval           (mtval),
        .valid_interrupt (valid_interrupt),
        .mret            (mret),
        .pipe_flush      (pipe_flush),
        .trap_busy       (trap_busy),
        .trap_redirect   (trap_redirect),
        .trap_target     (trap_target)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef enum {K_NONE, K_EXC, K_MRET, K_IRQ} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] cause;
        logic [31:0] tval;
        int          code;
    } res_t;

    logic [31:0] m_mepc, m_mcause, m_mtval, m_tgt;
    int          m_busy_left;               // cycles of flush/redirect still to come
    logic        m_ext_hist [IRQ_LAT];      // ext_irq delay line, [IRQ_LAT-1] is meip
    logic        m_mtip;

    task automatic model_reset();
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_tgt = 0;
        m_busy_left = 0; m_mtip = 1'b0;
        for (int i = 0; i < IRQ_LAT; i++) m_ext_hist[i] = 1'b0;
    endtask

    function automatic res_t resolve();
        res_t r;
        r.kind = K_NONE; r.cause = 0; r.tval = 0; r.code = 0;
        if (m_busy_left != 0 || !instr_valid_ex) return r;
        if      (exc_illegal)     begin r.kind = K_EXC; r.cause = 2;  r.tval = illegal_instr; end
        else if (exc_ebreak)      begin r.kind = K_EXC; r.cause = 3;  r.tval = pc_ex; end
        else if (exc_ecall)       begin r.kind = K_EXC; r.cause = 11; end
        else if (exc_ld_misalign) begin r.kind = K_EXC; r.cause = 4;  r.tval = mem_addr; end
        else if (exc_st_misalign) begin r.kind = K_EXC; r.cause = 6;  r.tval = mem_addr; end
        else if (mret_ex)         r.kind = K_MRET;
        else if (m_ext_hist[IRQ_LAT-1] && meie && mstatus_mie)
            begin r.kind = K_IRQ; r.cause = 32'h8000_000B; r.code = 11; end
        else if (m_mtip && mtie && mstatus_mie)
            begin r.kind = K_IRQ; r.cause = 32'h8000_0007; r.code = 7; end
        return r;
    endfunction

    function automatic logic [31:0] csr_ref(input logic [31:0] old_v);
        if (mcsr_set) return old_v | write_data;
        if (mcsr_clr) return old_v & ~write_data;
        return write_data;
    endfunction

    task automatic compare_all();
        res_t r;
        r = resolve();
        check("meip",      meip,            m_ext_hist[IRQ_LAT-1]);
        check("mtip",      mtip,            m_mtip);
        check("mepc",      mepc,            m_mepc);
        check("mcause",    mcause,          m_mcause);
        check("mtval",     mtval,           m_mtval);
        check("target",    trap_target,     m_tgt);
        check("valid_irq", valid_interrupt, r.kind == K_IRQ);
        check("mret",      mret,            r.kind == K_MRET);
        check("flush",     pipe_flush,      m_busy_left == 2);
        check("redirect",  trap_redirect,   m_busy_left == 1);
        check("busy",      trap_busy,       m_busy_left != 0);
    endtask

    task automatic model_update();
        res_t        r;
        logic [31:0] old_mepc;
        r = resolve();
        old_mepc = m_mepc;
        if (r.kind == K_EXC || r.kind == K_IRQ) begin
            m_mepc   = pc_ex;
            m_mcause = r.cause;
            m_mtval  = r.tval;
            m_tgt    = (r.kind == K_IRQ && mtvec_mode == 2'd1) ? mtvec_base + 32'(4 * r.code)
                                                               : mtvec_base;
            m_busy_left = 2;
        end else begin
            if (valid_mcsr_wr) begin
                if (mepc_sel)   m_mepc   = csr_ref(m_mepc) & ~32'h3;
                if (mcause_sel) m_mcause = csr_ref(m_mcause);
                if (mtval_sel)  m_mtval  = csr_ref(m_mtval);
            end
            if (r.kind == K_MRET) begin
                m_tgt = old_mepc;
                m_busy_left = 2;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
            end
        end
        for (int i = IRQ_LAT - 1; i > 0; i--) m_ext_hist[i] = m_ext_hist[i-1];
        m_ext_hist[0] = ext_irq;
        m_mtip = timer_irq;
    endtask

    // -------------------------------------------------------------- drivers
    task automatic clear_inputs();
        instr_valid_ex = 0; pc_ex = 0; exc_illegal = 0; illegal_instr = 0;
        exc_ebreak = 0; exc_ecall = 0; exc_ld_misalign = 0; exc_st_misalign = 0;
        mem_addr = 0; mret_ex = 0; ext_irq = 0; timer_irq = 0;
        meie = 0; mtie = 0; mstatus_mie = 0; mtvec_mode = 0; mtvec_base = 0;
        mepc_sel = 0; mcause_sel = 0; mtval_sel = 0;
        valid_mcsr_wr = 0; mcsr_set = 0; mcsr_clr = 0; write_data = 0;
    endtask

    task automatic rand_inputs();
        instr_valid_ex  = ($urandom_range(0, 3) != 0);
        pc_ex           = $urandom & ~32'h3;
        exc_illegal     = ($urandom_range(0, 15) == 0);
        illegal_instr   = $urandom;
        exc_ebreak      = ($urandom_range(0, 15) == 0);
        exc_ecall       = ($urandom_range(0, 15) == 0);
        exc_ld_misalign = ($urandom_range(0, 15) == 0);
        exc_st_misalign = ($urandom_range(0, 15) == 0);
        mem_addr        = $urandom;
        mret_ex         = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) ext_irq   = ~ext_irq;
        if ($urandom_range(0, 3) == 0) timer_irq = ~timer_irq;
        meie            = ($urandom_range(0, 3) != 0);
        mtie            = ($urandom_range(0, 3) != 0);
        mstatus_mie     = ($urandom_range(0, 3) != 0);
        mtvec_mode      = 2'($urandom_range(0, 3));
        mtvec_base      = $urandom & ~32'h3;
        valid_mcsr_wr   = ($urandom_range(0, 3) == 0);
        mepc_sel        = 1'($urandom_range(0, 1));
        mcause_sel      = 1'($urandom_range(0, 1));
        mtval_sel       = 1'($urandom_range(0, 1));
        mcsr_set        = 1'($urandom_range(0, 1));
        mcsr_clr        = 1'($urandom_range(0, 1));
        write_data      = $urandom;
    endtask

    // Inputs are driven in the low phase; outputs are compared 1 ns later,
    // the model advances as of the coming rising edge, then we wait for the
    // next falling edge.
    task automatic step();
        #1;
        compare_all();
        model_update();
        @(negedge cpu_clk);
    endtask

    task automatic idle_steps(input int n);
        clear_inputs();
        repeat (n) step();
    endtask

    task automatic do_reset();
        cpu_rstn = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        compare_all();
        repeat (2) begin
            @(posedge cpu_clk);
            #1;
            check("rst_redirect", trap_redirect, 1'b0);
            compare_all();
        end
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        do_reset();

        // Illegal instruction, direct vector.
        clear_inputs();
        instr_valid_ex = 1; exc_illegal = 1; illegal_instr = 0; pc_ex = 32'h100; mtvec_base = 32'h80;
        step();
        check("ill_mcause", mcause, 32'd2);
        check("ill_mtval",  mtval, 32'd0);
        check("ill_mepc",   mepc, 32'h100);
        check("ill_flush",  pipe_flush, 1'b1);
        clear_inputs();
        step();
        check("ill_redir",  trap_redirect, 1'b1);
        check("ill_target", trap_target, 32'h80);
        idle_steps(2);

        // External interrupt, vectored; held off while instr_valid_ex=0.
        ext_irq = 1; meie = 1; mstatus_mie = 1;
        repeat (IRQ_LAT + 1) step();
        check("ext_pending", meip, 1'b1);
        instr_valid_ex = 1; pc_ex = 32'h200; mtvec_mode = 1; mtvec_base = 32'h80;
        #1;
        check("ext_pulse", valid_interrupt, 1'b1);
        step();
        check("ext_mcause", mcause, 32'h8000_000B);
        check("ext_mepc",   mepc, 32'h200);
        check("ext_target", trap_target, 32'hAC);
        idle_steps(IRQ_LAT + 2);

        // ecall beats an enabled, pending timer interrupt.
        timer_irq = 1; mtie = 1; mstatus_mie = 1;
        step();
        instr_valid_ex = 1; exc_ecall = 1; pc_ex = 32'h240;
        #1;
        check("ecall_noirq", valid_interrupt, 1'b0);
        step();
        check("ecall_cause", mcause, 32'd11);
        idle_steps(3);

        // ebreak wins over a same-cycle mepc write.
        instr_valid_ex = 1; exc_ebreak = 1; pc_ex = 32'h300;
        valid_mcsr_wr = 1; mepc_sel = 1; write_data = 32'h1237;
        step();
        check("ebrk_mepc",  mepc, 32'h300);
        check("ebrk_mtval", mtval, 32'h300);
        idle_steps(2);

        // Plain mepc writes: low bits dropped.
        valid_mcsr_wr = 1; mepc_sel = 1; write_data = 32'h1237;
        step();
        check("csr_mepc_align", mepc, 32'h1234);
        valid_mcsr_wr = 1; mepc_sel = 1; write_data = 32'h204;
        step();
        check("csr_mepc", mepc, 32'h204);

        // mret back to mepc.
        clear_inputs();
        instr_valid_ex = 1; mret_ex = 1;
        #1;
        check("mret_pulse", mret, 1'b1);
        step();
        clear_inputs();
        step();
        check("mret_redir",  trap_redirect, 1'b1);
        check("mret_target", trap_target, 32'h204);
        idle_steps(1);

        // Reset pulsed during FLUSH.
        instr_valid_ex = 1; exc_illegal = 1; pc_ex = 32'h400; mtvec_base = 32'h80;
        step();
        check("rst_in_flush", pipe_flush, 1'b1);
        do_reset();
        step();
        check("rst_post_redir", trap_redirect, 1'b0);
        check("rst_post_busy",  trap_busy, 1'b0);
        check("rst_post_mepc",  mepc, 32'd0);
        idle_steps(2);

        // Randomized traffic with occasional resets.
        clear_inputs();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            rand_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
